seg_scan_rx: RTL and testbench
==============================

Name: seg_scan_rx

Overview:
Receiver for the multiplexed 8-digit seven-segment scan interface: anodes, segments a–g and dp, all active-low. It observes the scan pins and rebuilds the eight displayed hex digits and decimal points into registers. It detects completed scan frames and reports illegal patterns and a stalled scan. It serves as a loopback checker and capture front-end for the display path.

Parameters:
SETTLE, 16, consecutive cycles the synchronized pin vector must stay unchanged before a digit is captured (>=2)
TIMEOUT, 65536, cycles without a capture before lost asserts (>=SETTLE+2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
an  input  8  anode selects, active-low; bit i low = digit i lit
ca,cb,cc,cd,ce,cf,cg  input  1 each  segments a..g, active-low
dp  input  1  decimal point, active-low
digits  output  32  captured hex digits; digit i = digits[4i+3:4i]
dps  output  8  captured decimal points, active-high
valid  output  8  bit i = digit i last captured from a legal segment code
frame_done  output  1  one-cycle pulse when all 8 digits captured since last pulse
seg_err  output  1  one-cycle pulse on capture of unrecognized segment code
an_err  output  1  one-cycle pulse on capture attempt with >1 anode low
lost  output  1  level; high after TIMEOUT cycles with no capture

Behaviour:
- Reset (rst=0, asynchronous): digits=0, dps=0, valid=0, frame_done=0, seg_err=0, an_err=0, lost=0. Synchronizers, stability counter, frame mask and timeout counter are cleared. A reset mid-frame discards partial progress.
- All 16 pin bits pass a 2-flop synchronizer. Then invert to active-high: A[7:0]=~an, S={a,b,c,d,e,f,g}=~{ca..cg}, P=~dp.
- Stability counter: if the synced vector differs from the previous cycle, count=0 and captured_flag=0; else count saturates at SETTLE-1.
- Capture event: exactly one cycle per dwell, when count==SETTLE-1 and captured_flag==0. captured_flag is then set.
- At capture:
  - A==0: blanking. No capture, no error.
  - A one-hot, index i: decode S. On a legal code, digits[i]=value, valid[i]=1. On an unrecognized code, digits[i]=0, valid[i]=0, seg_err pulses. In both cases dps[i]=P and mask[i]=1.
  - A has >1 bit set: an_err pulses. No register changes.
- Latency: a pin change held stable reaches the outputs 2 (sync) + SETTLE + 1 cycles later.
- Decode table (S as abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - Any other code is illegal.
- Frame tracking:
  - When a capture makes mask==8'hFF, frame_done pulses the next cycle and mask clears to 0 in that same capture cycle.
  - Re-capturing an already-set digit before the frame completes just updates its value; the mask is unchanged.
- Timeout:
  - The counter increments every cycle and saturates at TIMEOUT; every successful one-hot capture resets it to 0.
  - lost=1 while counter==TIMEOUT; it falls the cycle after the next capture.
  - Blanking and an_err captures do not reset the counter.
- Pulse outputs are registered. seg_err and frame_done may pulse in the same cycle.

Test Plan:
- Reset release, idle pins (an=8'hFF, segs=1) for TIMEOUT+5 cycles -> digits=0, valid=0, no pulses; lost rises exactly at cycle TIMEOUT+1 after reset release.
- Scan digits 0..7 showing values 1,2,3,4,5,6,7,8, dwell 100 cycles each, dp low on digit 3 only:
  - Each digit updates 2+SETTLE+1 cycles after its anode falls.
  - After the digit-7 capture: digits=32'h87654321, dps=8'h08, valid=8'hFF.
  - frame_done pulses once.
- Digit 2 held with segs decoding 0x0000000 (illegal) -> seg_err single pulse, valid[2]=0, digits[11:8]=0. Neighbouring digits are unchanged.
- an=8'b1111_0011 held 50 cycles -> single an_err pulse, no register change, mask unchanged.
- Glitch test: pins change every 10 cycles (<SETTLE) -> no capture. Then hold 20 cycles -> exactly one capture.
- Scan digits 0..4, assert rst for 1 cycle, then scan all 8 -> frame_done fires only after all 8 post-reset captures; outputs zero immediately on reset assertion.

Source files
------------

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: receiver for a multiplexed 8-digit active-low seven-segment scan.
// Rebuilds the displayed hex digits and decimal points from the scan pins.
// Also flags completed frames, illegal segment codes, multi-anode patterns
// and a stalled scan.
module seg_scan_rx #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic        ca,
  input  logic        cb,
  input  logic        cc,
  input  logic        cd,
  input  logic        ce,
  input  logic        cf,
  input  logic        cg,
  input  logic        dp,
  output logic [31:0] digits,
  output logic [7:0]  dps,
  output logic [7:0]  valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        an_err,
  output logic        lost
);

  localparam int unsigned    CW      = $clog2(SETTLE);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SETTLE - 1);
  localparam int unsigned    TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  T_MAX   = TW'(TIMEOUT);

  logic [15:0]   r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_flag;
  logic [31:0]   r_digits;
  logic [7:0]    r_dps, r_valid, r_mask;
  logic          r_frame_done, r_seg_err, r_an_err, r_lost;
  logic [TW-1:0] r_tcnt;

  logic          w_changed, w_capture, w_cap_ok, w_onehot, w_multi, w_legal;
  logic [7:0]    w_a, w_bit, w_mask_nx;
  logic [6:0]    w_s;
  logic          w_p;
  logic [3:0]    w_val;
  logic [2:0]    w_idx;

  assign w_a       = ~r_sync2[15:8];
  assign w_s       = ~r_sync2[7:1];
  assign w_p       = ~r_sync2[0];
  assign w_changed = (r_sync2 != r_prev);
  assign w_capture = !w_changed && (r_cnt == CNT_MAX) && !r_flag;
  assign w_onehot  = $onehot(w_a);
  assign w_multi   = !w_onehot && (w_a != '0);
  assign w_cap_ok  = w_capture && w_onehot;
  assign w_bit     = 8'b1 << w_idx;
  assign w_mask_nx = r_mask | w_bit;

  // Two-flop synchronizer plus one-cycle history for change detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {an, ca, cb, cc, cd, ce, cf, cg, dp};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Stability counter; flag starts set so the cleared synchronizer contents
  // are never mistaken for an all-anodes-lit pattern after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_flag <= 1'b1;
    end else if (w_changed) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (w_capture)        r_flag <= 1'b1;
    end
  end

  // Segment code to hex value decode
  always_comb begin
    w_legal = 1'b1;
    w_val   = '0;
    case (w_s)
      7'b1111110: w_val = 4'h0;
      7'b0110000: w_val = 4'h1;
      7'b1101101: w_val = 4'h2;
      7'b1111001: w_val = 4'h3;
      7'b0110011: w_val = 4'h4;
      7'b1011011: w_val = 4'h5;
      7'b1011111: w_val = 4'h6;
      7'b1110000: w_val = 4'h7;
      7'b1111111: w_val = 4'h8;
      7'b1111011: w_val = 4'h9;
      7'b1110111: w_val = 4'hA;
      7'b0011111: w_val = 4'hB;
      7'b1001110: w_val = 4'hC;
      7'b0111101: w_val = 4'hD;
      7'b1001111: w_val = 4'hE;
      7'b1000111: w_val = 4'hF;
      default:    w_legal = 1'b0;
    endcase
  end

  // Index of the lit anode (meaningful only when exactly one is lit)
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_a[i]) w_idx = 3'(i);
    end
  end

  // Digit, decimal point and valid registers updated on one-hot captures
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits <= '0;
      r_dps    <= '0;
      r_valid  <= '0;
    end else if (w_cap_ok) begin
      r_digits[{w_idx, 2'b00} +: 4] <= w_legal ? w_val : 4'h0;
      r_valid[w_idx]                <= w_legal;
      r_dps[w_idx]                  <= w_p;
    end
  end

  // Frame mask and registered error/frame pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask       <= '0;
      r_frame_done <= 1'b0;
      r_seg_err    <= 1'b0;
      r_an_err     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_seg_err    <= w_cap_ok && !w_legal;
      r_an_err     <= w_capture && w_multi;
      if (w_cap_ok) begin
        if (&w_mask_nx) begin
          r_mask       <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_mask <= w_mask_nx;
        end
      end
    end
  end

  // Stall timeout: saturating counter cleared by every one-hot capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_lost <= 1'b0;
    end else begin
      if (w_cap_ok)             r_tcnt <= '0;
      else if (r_tcnt != T_MAX) r_tcnt <= r_tcnt + 1'b1;
      r_lost <= (r_tcnt == T_MAX);
    end
  end

  assign digits     = r_digits;
  assign dps        = r_dps;
  assign valid      = r_valid;
  assign frame_done = r_frame_done;
  assign seg_err    = r_seg_err;
  assign an_err     = r_an_err;
  assign lost       = r_lost;

endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: scoreboard bench for seg_scan_rx. The driver predicts the
// register state and pulses each dwell should produce and when they should appear.
module tb_seg_scan_rx;

  localparam int unsigned SETTLE  = 16;
  localparam int unsigned TIMEOUT = 200;
  localparam logic [7:0]  BLANK   = 8'hFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  an  = BLANK;
  logic        ca = 1'b1, cb = 1'b1, cc = 1'b1, cd = 1'b1, ce = 1'b1, cf = 1'b1, cg = 1'b1;
  logic        dp = 1'b1;
  logic [31:0] digits;
  logic [7:0]  dps, valid;
  logic        frame_done, seg_err, an_err, lost;

  seg_scan_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .an(an),
    .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg), .dp(dp),
    .digits(digits), .dps(dps), .valid(valid),
    .frame_done(frame_done), .seg_err(seg_err), .an_err(an_err), .lost(lost)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [31:0] dig;
    logic [7:0]  dps, val;
    logic        fd, se, ae, lost;
  } rec_t;
  rec_t q[$];

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned n_fd = 0, n_se = 0, n_ae = 0;
  int unsigned e_fd = 0, e_se = 0, e_ae = 0;

  // Reference model state
  logic [31:0] m_dig = '0;
  logic [7:0]  m_dps = '0, m_val = '0, m_mask = '0;
  logic [15:0] last_v = '1;
  int          t_last = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic rec_t mk(input int unsigned c, input string tag, input logic fd,
                              input logic se, input logic ae, input logic ls);
    rec_t r;
    r.cyc = c; r.tag = tag; r.dig = m_dig; r.dps = m_dps; r.val = m_val;
    r.fd = fd; r.se = se; r.ae = ae; r.lost = ls;
    return r;
  endfunction

  // Scoreboard side: count pulses and compare due records
  always @(negedge clk) begin
    if (frame_done === 1'b1) n_fd++;
    if (seg_err === 1'b1)    n_se++;
    if (an_err === 1'b1)     n_ae++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      rec_t r;
      r = q.pop_front();
      check({r.tag, " when"}, cyc, r.cyc);
      check({r.tag, " digits"}, digits, r.dig);
      check({r.tag, " dps"}, {24'h0, dps}, {24'h0, r.dps});
      check({r.tag, " valid"}, {24'h0, valid}, {24'h0, r.val});
      check({r.tag, " frame_done"}, {31'h0, frame_done}, {31'h0, r.fd});
      check({r.tag, " seg_err"}, {31'h0, seg_err}, {31'h0, r.se});
      check({r.tag, " an_err"}, {31'h0, an_err}, {31'h0, r.ae});
      check({r.tag, " lost"}, {31'h0, lost}, {31'h0, r.lost});
    end
  end

  // Drive one pin pattern for dwell cycles and push the predicted outcome
  task automatic drive(input string tag, input logic [7:0] an_v, input logic [6:0] s,
                       input logic p, input int unsigned dwell);
    logic [15:0] v;
    logic [7:0]  a;
    int          c, t, idx;
    logic        leg, fd;
    logic [3:0]  val;
    v = {an_v, ~s, ~p};
    a = ~an_v;
    c = int'(cyc);
    an = an_v;
    {ca, cb, cc, cd, ce, cf, cg} = ~s;
    dp = ~p;
    if (v != last_v && dwell >= SETTLE + 1 && a != '0) begin
      t = c + int'(SETTLE) + 3;
      if ($onehot(a)) begin
        q.push_back(mk(t - 1, {tag, " pre"}, 1'b0, 1'b0, 1'b0, (t - 2 - t_last) >= int'(TIMEOUT)));
        idx = 0;
        for (int i = 0; i < 8; i++) if (a[i]) idx = i;
        leg = 1'b0; val = '0;
        for (int k = 0; k < 16; k++) if (seg_tab[k] == s) begin leg = 1'b1; val = 4'(k); end
        m_dig[4*idx +: 4] = leg ? val : 4'h0;
        m_val[idx] = leg;
        m_dps[idx] = p;
        m_mask[idx] = 1'b1;
        fd = &m_mask;
        if (fd) begin m_mask = '0; e_fd++; end
        if (!leg) e_se++;
        q.push_back(mk(t, tag, fd, !leg, 1'b0, (t - 1 - t_last) >= int'(TIMEOUT)));
        t_last = t;
      end else begin
        e_ae++;
        q.push_back(mk(t, tag, 1'b0, 1'b0, 1'b1, (t - 1 - t_last) >= int'(TIMEOUT)));
      end
    end
    last_v = v;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic scan(input int unsigned i, input logic [3:0] val, input logic p);
    logic [7:0] a;
    a = ~(8'b1 << i);
    drive($sformatf("digit%0d", i), a, seg_tab[val], p, 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset digits", digits, 32'h0);
    check("reset flags", {valid, dps, 4'h0, frame_done, seg_err, an_err, lost}, 28'h0);

    // Idle after release: lost rises exactly TIMEOUT+1 cycles later
    rst = 1'b1;
    t_last = int'(cyc);
    q.push_back(mk(cyc + TIMEOUT, "idle", 1'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(cyc + TIMEOUT + 1, "lost rise", 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (TIMEOUT + 5) @(negedge clk);

    // Frame of 1..8 with dp on digit 3
    for (int unsigned i = 0; i < 8; i++) scan(i, 4'(i + 1), i == 3);
    check("frame digits", m_dig, 32'h87654321);

    // Illegal code on digit 2, then two anodes lit together
    drive("illegal", 8'b1111_1011, 7'b0000000, 1'b0, 60);
    drive("two anodes", 8'b1111_0011, seg_tab[3], 1'b0, 50);

    // Glitching pins never settle, then one steady hold captures once
    for (int unsigned k = 0; k < 6; k++) begin
      if (k % 2 == 0) drive("glitch", 8'b1101_1111, seg_tab[9], 1'b0, 10);
      else            drive("glitch", 8'b1011_1111, seg_tab[10], 1'b1, 10);
    end
    drive("hold", 8'b1101_1111, seg_tab[9], 1'b0, 20);
    drive("blank", BLANK, 7'b0, 1'b0, 30);

    // Partial frame, reset, then a full frame
    for (int unsigned i = 0; i < 5; i++) scan(i, 4'(15 - i), 1'b0);
    drive("blank", BLANK, 7'b0, 1'b0, 30);
    check("queue drained", q.size(), 0);
    rst = 1'b0;
    #1;
    check("mid reset digits", digits, 32'h0);
    check("mid reset flags", {valid, dps, 4'h0, frame_done, seg_err, an_err, lost}, 28'h0);
    @(negedge clk);
    rst = 1'b1;
    t_last = int'(cyc);
    m_dig = '0; m_dps = '0; m_val = '0; m_mask = '0;
    drive("blank", BLANK, 7'b0, 1'b0, 5);
    for (int unsigned i = 0; i < 8; i++) scan(i, (i == 0) ? 4'h0 : 4'(8 + i), i[0]);
    repeat (5) @(negedge clk);

    check("pending records", q.size(), 0);
    check("frame_done count", n_fd, e_fd);
    check("seg_err count", n_se, e_se);
    check("an_err count", n_ae, e_ae);
    check("expected frames", e_fd, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
